// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter driven by a prescaler tick.
// Emits a one-cycle done pulse on expiry; optional periodic auto-reload.
module countdown_timer #(
    parameter int MAXIMUM_VALUE     = 32,
    parameter int NBITS_FOR_COUNTER = $clog2(MAXIMUM_VALUE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NBITS_FOR_COUNTER-1:0] load_value,
    input  logic                         auto_reload,
    input  logic                         tick,
    input  logic                         abort,
    output logic [NBITS_FOR_COUNTER-1:0] count,
    output logic                         busy,
    output logic                         done
);

    localparam int W = NBITS_FOR_COUNTER;
    localparam logic [W-1:0] MAX_LOAD = W'(MAXIMUM_VALUE - 1);
    localparam logic [W-1:0] ONE      = W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_reload;
    logic           r_auto;
    logic           r_busy;
    logic           r_done;
    logic [W-1:0]   w_load;
    logic           w_last;

    // Clamp only exists when the width can hold values past the bound.
    generate
        if ((1 << W) > MAXIMUM_VALUE) begin : g_clamp
            assign w_load = (load_value > MAX_LOAD) ? MAX_LOAD : load_value;
        end else begin : g_noclamp
            assign w_load = load_value;
        end
    endgenerate

    assign w_last = ~(r_count > ONE);

    // Control FSM with registered count/busy/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_auto   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_count  <= w_load;
                            r_reload <= w_load;
                            r_auto   <= auto_reload;
                            if (w_load == '0) begin
                                r_state <= S_FINISH;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (tick) begin
                            if (!w_last) begin
                                r_count <= r_count - ONE;
                            end else if (r_auto) begin
                                r_count <= r_reload;
                                r_done  <= 1'b1;
                            end else begin
                                r_count <= '0;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_FINISH;
                            end
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: vector table, corner sequences and random run
// against a tick-counting reference model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] load_value = '0;
    logic       auto_reload = 1'b0;
    logic       tick = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] count, count20;
    logic       busy, busy20;
    logic       done, done20;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    countdown_timer #(.MAXIMUM_VALUE(32)) dut (
        .clk(clk), .reset(rst_n), .start(start),
        .load_value(load_value), .auto_reload(auto_reload),
        .tick(tick), .abort(abort),
        .count(count), .busy(busy), .done(done)
    );

    countdown_timer #(.MAXIMUM_VALUE(20)) dut20 (
        .clk(clk), .reset(rst_n), .start(start),
        .load_value(load_value), .auto_reload(auto_reload),
        .tick(tick), .abort(abort),
        .count(count20), .busy(busy20), .done(done20)
    );

    // Reference: remaining ticks, period, and whether a pulse is showing.
    typedef struct {
        int rem;
        int per;
        bit periodic;
        bit busy;
        bit done;
    } mdl_t;

    mdl_t m32, m20;

    function automatic mdl_t mreset();
        mdl_t m;
        m.rem = 0; m.per = 0; m.periodic = 0;
        m.busy = 0; m.done = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit st, int ld, bit ar,
                                   bit tk, bit ab, int mx);
        mdl_t n = m;
        bit idle = !m.busy && !m.done;
        n.done = 0;
        if (ab) begin
            n.busy = 0;
            n.rem = 0;
        end else if (idle && st) begin
            int v = (ld > mx - 1) ? mx - 1 : ld;
            n.rem = v;
            n.per = v;
            n.periodic = ar;
            if (v == 0) n.done = 1;
            else n.busy = 1;
        end else if (m.busy && tk) begin
            if (m.rem > 1) begin
                n.rem = m.rem - 1;
            end else begin
                n.done = 1;
                if (m.periodic) begin
                    n.rem = m.per;
                end else begin
                    n.rem = 0;
                    n.busy = 0;
                end
            end
        end
        return n;
    endfunction

    typedef struct {
        bit       st;
        bit [4:0] ld;
        bit       ar;
        bit       tk;
        bit       ab;
        int       ec;
        bit       eb;
        bit       ed;
    } vec_t;

    task automatic chk(string nm, logic [4:0] c, logic b, logic d,
                       int ec, bit eb, bit ed);
        n_total++;
        if (int'(c) == ec && b == eb && d == ed) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                     nm, c, b, d, ec, eb, ed);
        end
    endtask

    task automatic chk1(string nm, int got, int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, want);
    endtask

    task automatic drive(bit st, bit [4:0] ld, bit ar, bit tk, bit ab);
        start = st;
        load_value = ld;
        auto_reload = ar;
        tick = tk;
        abort = ab;
    endtask

    // One clock: models follow the same sampled inputs, then settle.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            m32 = mreset();
            m20 = mreset();
        end else begin
            m32 = mstep(m32, start, int'(load_value), auto_reload,
                        tick, abort, 32);
            m20 = mstep(m20, start, int'(load_value), auto_reload,
                        tick, abort, 20);
        end
        #1;
    endtask

    task automatic chk_models(string nm);
        chk({nm, "/32"}, count, busy, done, m32.rem, m32.busy, m32.done);
        chk({nm, "/20"}, count20, busy20, done20,
            m20.rem, m20.busy, m20.done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[18];
        int   pulses;
        int   lows;

        vt[0]  = '{1, 5'd3, 0, 1, 0, 3, 1, 0};
        vt[1]  = '{0, 5'd0, 0, 0, 0, 3, 1, 0};
        vt[2]  = '{0, 5'd0, 0, 1, 0, 2, 1, 0};
        vt[3]  = '{1, 5'd9, 0, 0, 0, 2, 1, 0};
        vt[4]  = '{0, 5'd0, 0, 1, 0, 1, 1, 0};
        vt[5]  = '{0, 5'd0, 0, 1, 0, 0, 0, 1};
        vt[6]  = '{1, 5'd5, 0, 0, 0, 0, 0, 0};
        vt[7]  = '{1, 5'd0, 0, 0, 0, 0, 0, 1};
        vt[8]  = '{0, 5'd0, 0, 1, 0, 0, 0, 0};
        vt[9]  = '{1, 5'd2, 1, 0, 0, 2, 1, 0};
        vt[10] = '{0, 5'd0, 0, 1, 0, 1, 1, 0};
        vt[11] = '{0, 5'd0, 0, 1, 0, 2, 1, 1};
        vt[12] = '{0, 5'd0, 0, 1, 0, 1, 1, 0};
        vt[13] = '{0, 5'd0, 0, 1, 1, 0, 0, 0};
        vt[14] = '{0, 5'd0, 0, 0, 0, 0, 0, 0};
        vt[15] = '{1, 5'd4, 0, 1, 0, 4, 1, 0};
        vt[16] = '{0, 5'd0, 0, 1, 0, 3, 1, 0};
        vt[17] = '{0, 5'd0, 0, 0, 1, 0, 0, 0};

        m32 = mreset();
        m20 = mreset();
        repeat (3) cycle();
        chk("reset_state", count, busy, done, 0, 0, 0);
        rst_n = 1'b1;
        cycle();
        chk("post_release", count, busy, done, 0, 0, 0);

        foreach (vt[i]) begin
            drive(vt[i].st, vt[i].ld, vt[i].ar, vt[i].tk, vt[i].ab);
            cycle();
            chk($sformatf("vec%0d", i), count, busy, done,
                vt[i].ec, vt[i].eb, vt[i].ed);
        end
        drive(0, 0, 0, 0, 0);
        cycle();

        // Async reset mid-countdown at count 7.
        drive(1, 5'd7, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        chk("pre_reset7", count, busy, done, 7, 1, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset", count, busy, done, 0, 0, 0);
        cycle();
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            cycle();
            if (done) pulses++;
        end
        chk1("no_done_after_reset", pulses, 0);
        chk("idle_after_reset", count, busy, done, 0, 0, 0);

        // One-shot, load 3, tick every 4th cycle.
        drive(1, 5'd3, 0, 0, 0);
        cycle();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, (i % 4) == 3, 0);
            cycle();
            if (done) pulses++;
        end
        chk1("oneshot_pulses", pulses, 1);
        chk("oneshot_finish", count, busy, done, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        cycle();
        chk("oneshot_idle", count, busy, done, 0, 0, 0);

        // Clamp: bound 20 loads 25 as 19.
        drive(1, 5'd25, 0, 0, 0);
        cycle();
        chk("clamp20", count20, busy20, done20, 19, 1, 0);
        chk("noclamp32", count, busy, done, 25, 1, 0);
        drive(0, 0, 0, 0, 1);
        cycle();

        // Auto-reload load 2, ten back-to-back ticks.
        drive(1, 5'd2, 1, 0, 0);
        cycle();
        pulses = 0;
        lows = 0;
        drive(0, 0, 0, 1, 0);
        repeat (10) begin
            cycle();
            if (done) pulses++;
            if (!busy) lows++;
        end
        chk1("reload2_pulses", pulses, 5);
        chk1("reload2_busy_low", lows, 0);
        chk("reload2_end", count, busy, done, 2, 1, 1);

        // Auto-reload load 1: done on every ticked cycle.
        drive(0, 0, 0, 0, 1);
        cycle();
        drive(1, 5'd1, 1, 0, 0);
        cycle();
        pulses = 0;
        drive(0, 0, 0, 1, 0);
        repeat (6) begin
            cycle();
            if (done) pulses++;
        end
        chk1("reload1_pulses", pulses, 6);

        // Start with coincident tick: four more ticks needed.
        drive(0, 0, 0, 0, 1);
        cycle();
        drive(1, 5'd4, 0, 1, 0);
        cycle();
        chk("coinc_load", count, busy, done, 4, 1, 0);
        pulses = 0;
        drive(0, 0, 0, 1, 0);
        repeat (3) begin
            cycle();
            if (done) pulses++;
        end
        chk1("coinc_early", pulses, 0);
        cycle();
        chk("coinc_done", count, busy, done, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        cycle();
        chk_models("sync_models");

        // Randomized run against the reference models.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 4) == 0, 5'($urandom),
                  1'($urandom), 1'($urandom),
                  ($urandom % 25) == 0);
            cycle();
            chk_models($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
